// File: rtl/sha256_round_engine_if.sv
// Block request / digest handshake between the padder/controller and the SHA-256 engine.
interface sha256_round_engine_if;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] h_in;
    logic         busy;
    logic         done;
    logic [255:0] digest_out;

    modport master (output start, block_in, h_in, input busy, done, digest_out);
    modport slave  (input start, block_in, h_in, output busy, done, digest_out);
endinterface

// File: rtl/sha256_round_engine.sv
// SHA-256 compression of one 512-bit block: 64 rounds, one per clock, with K[t]
// fetched from an external memory of K_LATENCY read latency.
module sha256_round_engine #(
    parameter int K_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    sha256_round_engine_if.slave        bus,
    output logic [5:0]                  k_addr,
    input  logic [31:0]                 k_in
);
    typedef enum logic [1:0] {IDLE, PRIME, ROUND, FINAL} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] w  [16];   // w[0] is W[t] of the current round
    logic [31:0] v  [8];    // working variables a..h
    logic [31:0] hv [8];    // chaining value captured at accept
    logic [31:0] t1, t2, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.busy  = (state != IDLE);
        unique case (state)
            IDLE:  if (bus.start) state_nxt = PRIME;
            PRIME: if (cnt == 6'(K_LATENCY - 1)) state_nxt = ROUND;
            ROUND: if (cnt == 6'd63) state_nxt = FINAL;
            FINAL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_in + w[0];
        t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        // W[t+16] from the window; enters at the tail as the window shifts
        w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt            <= '0;
            k_addr         <= '0;
            bus.done       <= 1'b0;
            bus.digest_out <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt    <= '0;
                    k_addr <= '0;
                end
                PRIME: begin
                    // address runs K_LATENCY ahead of the round index from here on
                    k_addr <= k_addr + 6'd1;
                    cnt    <= (cnt == 6'(K_LATENCY - 1)) ? 6'd0 : cnt + 6'd1;
                end
                ROUND: begin
                    k_addr <= k_addr + 6'd1;
                    cnt    <= cnt + 6'd1;
                end
                FINAL: begin
                    k_addr   <= '0;
                    cnt      <= '0;
                    bus.done <= 1'b1;
                    for (int i = 0; i < 8; i++)
                        bus.digest_out[255-32*i -: 32] <= hv[i] + v[i];
                end
                default: ;
            endcase
        end
    end

    // Datapath needs no reset: it is fully loaded on every accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            for (int i = 0; i < 16; i++) w[i] <= bus.block_in[511-32*i -: 32];
            for (int i = 0; i < 8; i++) begin
                v[i]  <= bus.h_in[255-32*i -: 32];
                hv[i] <= bus.h_in[255-32*i -: 32];
            end
        end else if (state == ROUND) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_new;
            v[0]  <= t1 + t2;
            v[1]  <= v[0];
            v[2]  <= v[1];
            v[3]  <= v[2];
            v[4]  <= v[3] + t1;
            v[5]  <= v[4];
            v[6]  <= v[5];
            v[7]  <= v[6];
        end
    end
endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench: known SHA-256 vectors on K_LATENCY=1 and 2 engines, scoreboard of digests.
module tb_sha256_round_engine;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic [31:0] ktab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    sha256_round_engine_if bus1();
    sha256_round_engine_if bus2();
    logic [5:0]  k_addr1, k_addr2;
    logic [31:0] k_in1, k_in2, kd2;

    sha256_round_engine #(.K_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1), .k_addr(k_addr1), .k_in(k_in1));
    sha256_round_engine #(.K_LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2), .k_addr(k_addr2), .k_in(k_in2));

    // compute_memory models with 1- and 2-cycle read latency
    always @(posedge clk) begin
        k_in1 <= ktab[k_addr1];
        kd2   <= ktab[k_addr2];
        k_in2 <= kd2;
    end

    int total = 0;
    int bad = 0;
    logic [255:0] sb [$];
    logic [255:0] last1 = '0;
    logic [255:0] last2 = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 1) ? bus1.done : bus2.done;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 1) ? bus1.busy : bus2.busy;
    endfunction
    function automatic logic [255:0] get_dig(input int sel);
        return (sel == 1) ? bus1.digest_out : bus2.digest_out;
    endfunction
    function automatic logic [5:0] get_ka(input int sel);
        return (sel == 1) ? k_addr1 : k_addr2;
    endfunction
    function automatic logic [255:0] get_last(input int sel);
        return (sel == 1) ? last1 : last2;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [511:0] blk, input logic [255:0] hin);
        if (sel == 1) begin bus1.start = st; bus1.block_in = blk; bus1.h_in = hin; end
        else          begin bus2.start = st; bus2.block_in = blk; bus2.h_in = hin; end
    endtask

    task automatic set_start(input int sel, input logic st);
        if (sel == 1) bus1.start = st;
        else          bus2.start = st;
    endtask

    // Entered at the negedge just after the accept edge; n = edges since accept when done seen.
    task automatic wait_done(input int sel, input int lat, input bit disturb, output int n, output int terr);
        n = 0;
        terr = 0;
        while (!get_done(sel) && n < 300) begin
            if (get_dig(sel) !== get_last(sel)) terr++;
            if (get_busy(sel) !== 1'b1) terr++;
            if (n >= lat && n < lat + 64 && get_ka(sel) !== 6'(n)) terr++;
            if (disturb) begin
                if (n == 5 || n == 40) drive(sel, 1'b1, {16{$urandom()}}, {8{$urandom()}});
                else set_start(sel, 1'b0);
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_done(input string tag, input int sel, input int n, input int lat, input int terr);
        logic [255:0] exp;
        chk({tag, "_latency"}, 256'(n), 256'(lat));
        chk({tag, "_trace"}, 256'(terr), 256'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 256'(sb.size()), 256'd1);
            exp = '0;
        end else begin
            exp = sb.pop_front();
        end
        chk({tag, "_digest"}, get_dig(sel), exp);
        chk({tag, "_busy_at_done"}, 256'(get_busy(sel)), 256'd0);
        chk({tag, "_kaddr_idle"}, 256'(get_ka(sel)), 256'd0);
        if (sel == 1) last1 = exp;
        else          last2 = exp;
    endtask

    task automatic run(input string tag, input int sel, input logic [511:0] blk, input logic [255:0] hin,
                       input logic [255:0] exp, input int lat, input bit disturb);
        int n, terr;
        sb.push_back(exp);
        drive(sel, 1'b1, blk, hin);
        @(negedge clk);
        set_start(sel, 1'b0);
        wait_done(sel, lat, disturb, n, terr);
        check_done(tag, sel, n, lat, terr);
    endtask

    initial begin
        int n, terr, cnt;
        drive(1, 1'b0, '0, '0);
        drive(2, 1'b0, '0, '0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy1", 256'(bus1.busy), 256'd0);
        chk("rst_done1", 256'(bus1.done), 256'd0);
        chk("rst_dig1", bus1.digest_out, 256'd0);
        chk("rst_kaddr1", 256'(k_addr1), 256'd0);
        chk("rst_busy2", 256'(bus2.busy), 256'd0);
        chk("rst_dig2", bus2.digest_out, 256'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_kaddr1", 256'(k_addr1), 256'd0);

        run("abc", 1, ABC, IV, D_ABC, 66, 1'b0);
        run("empty", 1, EMPTY, IV, D_EMP, 66, 1'b0);
        run("abc_l2", 2, ABC, IV, D_ABC, 67, 1'b0);

        // start pulses and block changes while busy must not disturb the result
        run("busy_start", 1, ABC, IV, D_ABC, 66, 1'b1);
        drive(1, 1'b0, ABC, IV);
        cnt = 0;
        repeat (80) begin @(negedge clk); if (bus1.done) cnt++; end
        chk("single_done", 256'(cnt), 256'd0);

        // abort around round 30, then a clean run
        drive(1, 1'b1, ABC, IV);
        @(negedge clk);
        set_start(1, 1'b0);
        cnt = 0;
        repeat (30) begin @(negedge clk); if (bus1.done) cnt++; end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", 256'(bus1.busy), 256'd0);
        chk("abort_dig", bus1.digest_out, 256'd0);
        chk("abort_kaddr", 256'(k_addr1), 256'd0);
        last1 = '0;
        repeat (80) begin @(negedge clk); if (bus1.done) cnt++; end
        chk("abort_no_done", 256'(cnt), 256'd0);
        chk("abort_dig_held", bus1.digest_out, 256'd0);
        run("after_abort", 1, ABC, IV, D_ABC, 66, 1'b0);

        // start held high through the done cycle: second block accepted at its end
        sb.push_back(D_ABC);
        sb.push_back(D_ABC);
        drive(1, 1'b1, ABC, IV);
        @(negedge clk);
        wait_done(1, 1, 1'b0, n, terr);
        check_done("b2b_first", 1, n, 66, terr);
        @(negedge clk);
        set_start(1, 1'b0);
        chk("b2b_accept", 256'(bus1.busy), 256'd1);
        wait_done(1, 1, 1'b0, n, terr);
        check_done("b2b_second", 1, n, 66, terr);
        chk("sb_drained", 256'(sb.size()), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
